// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
package fifo_pkg;

  localparam int DATA_W = 8;

  // FSM state encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the final count.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Counter held at zero while cleared; wraps to zero on each bit boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             r_cnt <= '0;
    else if (clr || tick)  r_cnt <= '0;
    else                   r_cnt <= r_cnt + 1'b1;
  end

  assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that pulls bytes from an external registered-read FIFO.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_idx, w_idx_nxt;
  logic              r_tx, w_tx_nxt;
  logic              w_clr, w_tick, w_done;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state, bit index, and the line level for the upcoming cycle
  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    w_clr     = 1'b1;
    w_done    = 1'b0;
    w_tx_nxt  = 1'b1;
    case (r_state)
      IDLE:  if (tx_en && !fifo_empty) w_next = REQ;
      REQ:   w_next = LATCH;
      LATCH: w_next = START;
      START: begin
        w_clr = 1'b0;
        if (w_tick) begin
          w_next    = DATA;
          w_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        w_clr = 1'b0;
        if (w_tick) begin
          if (r_idx == 3'd7) w_next    = STOP;
          else               w_idx_nxt = r_idx + 3'd1;
        end
      end
      STOP: begin
        w_clr = 1'b0;
        if (w_tick) begin
          w_done = 1'b1;
          w_next = (tx_en && !fifo_empty) ? REQ : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // tx is registered from the next state so the pin never glitches
    case (w_next)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_shift[w_idx_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Datapath: line register, bit index, byte capture on leaving LATCH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx    <= 1'b1;
      r_idx   <= 3'd0;
      r_shift <= '0;
    end else begin
      r_tx  <= w_tx_nxt;
      r_idx <= w_idx_nxt;
      if (r_state == LATCH) r_shift <= fifo_data;
    end
  end

  assign fifo_rd_en = (r_state == REQ);
  assign busy       = (r_state != IDLE);
  assign tx         = r_tx;
  assign tx_done    = w_done;

endmodule
